mem_arbiter: RTL and testbench

Arbitrates the single RAM port between the request unit's instruction-fetch channel (iREN/iaddr) and data channel (dREN/dWEN/daddr/dstore). It sits between the request unit (or caches) and RAM. It grants one channel at a time and forwards that channel's access to RAM. Data accesses have priority, and a streak limit prevents instruction-fetch starvation. A timeout guard releases the port if RAM never answers.

---
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the request unit, the arbiter and the RAM port.
// The slave view belongs to the arbiter; the master view is its environment.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single RAM port arbiter: data channel has priority, instruction fetch is
// forced after MAX_DSTREAK data grants, and a stalled RAM access is abandoned.
//   state | meaning
//   IDLE  | no grant; arbitrate pending requests
//   IGNT  | instruction fetch owns the RAM port
//   DGNT  | data access owns the RAM port
module mem_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input logic         CLK,
  input logic         RST,
  mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] SMAX     = SW'(MAX_DSTREAK);
  localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [7:0]    tmo_q, tmo_d;

  logic        dreq;
  logic        ram_ren, ram_wen, err;
  logic [31:0] ram_addr, ram_store, iload, dload;

  assign dreq = bus.dREN | bus.dWEN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      streak_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    tmo_d     = tmo_q;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    iload     = '0;
    dload     = '0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (!bus.iREN) streak_d = '0;
        if (dreq && (streak_q < SMAX || !bus.iREN)) state_d = DGNT;
        else if (bus.iREN)                          state_d = IGNT;
      end
      IGNT: begin
        ram_ren  = bus.iREN;
        ram_addr = bus.iaddr;
        // a dropped request aborts quietly, before completion or timeout
        if (!bus.iREN) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else if (bus.ramready) begin
          iload    = bus.ramload;
          streak_d = '0;
          state_d  = IDLE;
          tmo_d    = '0;
        end else if (tmo_q == TMO_LAST) begin
          err     = 1'b1;
          state_d = IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      DGNT: begin
        ram_wen   = bus.dWEN;
        ram_ren   = bus.dREN & ~bus.dWEN;
        ram_addr  = bus.daddr;
        ram_store = bus.dstore;
        if (!dreq) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else if (bus.ramready) begin
          if (bus.dREN && !bus.dWEN) dload = bus.ramload;
          if (bus.iREN && streak_q != SMAX) streak_d = streak_q + 1'b1;
          state_d = IDLE;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          err     = 1'b1;
          state_d = IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tmo_d   = '0;
      end
    endcase
  end

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.iload    = iload;
  assign bus.dload    = dload;
  assign bus.err      = err;
  assign bus.iwait    = bus.iREN & ~(state_q == IGNT && bus.ramready);
  assign bus.dwait    = dreq & ~(state_q == DGNT && bus.ramready);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written
// starvation and timeout sequences.
module tb_mem_arbiter;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic        rst, iren;
    logic [31:0] iaddr;
    logic        dren, dwen;
    logic [31:0] daddr, dstore, rload;
    logic        rrdy;
  } in_t;

  typedef struct packed {
    logic        rren, rwen;
    logic [31:0] raddr, rstore;
    logic        iw, dw;
    logic [31:0] iload, dload;
    logic        err;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  function automatic in_t I(logic rst, logic iren, logic [31:0] iaddr, logic dren, logic dwen,
                            logic [31:0] daddr, logic [31:0] dstore, logic [31:0] rload, logic rrdy);
    in_t v;
    v = '{rst, iren, iaddr, dren, dwen, daddr, dstore, rload, rrdy};
    return v;
  endfunction

  function automatic out_t O(logic rren, logic rwen, logic [31:0] raddr, logic [31:0] rstore,
                             logic iw, logic dw, logic [31:0] iload, logic [31:0] dload, logic err);
    out_t v;
    v = '{rren, rwen, raddr, rstore, iw, dw, iload, dload, err};
    return v;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t v);
    @(negedge CLK);
    RST          = v.rst;
    bus.iREN     = v.iren;
    bus.iaddr    = v.iaddr;
    bus.dREN     = v.dren;
    bus.dWEN     = v.dwen;
    bus.daddr    = v.daddr;
    bus.dstore   = v.dstore;
    bus.ramload  = v.rload;
    bus.ramready = v.rrdy;
    #1;
  endtask

  function automatic out_t sample();
    out_t a;
    a = '{bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.iwait, bus.dwait,
          bus.iload, bus.dload, bus.err};
    return a;
  endfunction

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    out_t a;
    int dcomp;
    logic seen_i;
    RST = 1'b1;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramready = 0;
    repeat (2) @(posedge CLK);

    // reset and single instruction read with two wait cycles
    add(I(1,0,32'h0,0,0,32'h0,32'h0,32'h0,0),        O(0,0,32'h0,32'h0,0,0,32'h0,32'h0,0));
    add(I(0,1,32'h40,0,0,32'h0,32'h0,32'h0,0),       O(0,0,32'h0,32'h0,1,0,32'h0,32'h0,0));
    add(I(0,1,32'h40,0,0,32'h0,32'h0,32'h0,0),       O(1,0,32'h40,32'h0,1,0,32'h0,32'h0,0));
    add(I(0,1,32'h40,0,0,32'h0,32'h0,32'h0,0),       O(1,0,32'h40,32'h0,1,0,32'h0,32'h0,0));
    add(I(0,1,32'h40,0,0,32'h0,32'h0,32'h8C220004,1),O(1,0,32'h40,32'h0,0,0,32'h8C220004,32'h0,0));
    add(I(0,0,32'h40,0,0,32'h0,32'h0,32'hDEAD0000,1),O(0,0,32'h0,32'h0,0,0,32'h0,32'h0,0));
    // contention: data first, bubble, then instruction
    add(I(0,1,32'h80,0,1,32'h100,32'hDEADBEEF,32'h0,0),        O(0,0,32'h0,32'h0,1,1,32'h0,32'h0,0));
    add(I(0,1,32'h80,0,1,32'h100,32'hDEADBEEF,32'h0,0),        O(0,1,32'h100,32'hDEADBEEF,1,1,32'h0,32'h0,0));
    add(I(0,1,32'h80,0,1,32'h100,32'hDEADBEEF,32'h12345678,1), O(0,1,32'h100,32'hDEADBEEF,1,0,32'h0,32'h0,0));
    add(I(0,1,32'h80,0,0,32'h100,32'hDEADBEEF,32'h0,0),        O(0,0,32'h0,32'h0,1,0,32'h0,32'h0,0));
    add(I(0,1,32'h80,0,0,32'h100,32'hDEADBEEF,32'hCAFEF00D,1), O(1,0,32'h80,32'h0,0,0,32'hCAFEF00D,32'h0,0));
    // read/write conflict: write wins, no read data
    add(I(0,0,32'h80,1,1,32'h200,32'h55AA55AA,32'h0,0),        O(0,0,32'h0,32'h0,0,1,32'h0,32'h0,0));
    add(I(0,0,32'h80,1,1,32'h200,32'h55AA55AA,32'h11111111,1), O(0,1,32'h200,32'h55AA55AA,0,0,32'h0,32'h0,0));
    // data read
    add(I(0,0,32'h0,1,0,32'h300,32'h0,32'h0,0),        O(0,0,32'h0,32'h0,0,1,32'h0,32'h0,0));
    add(I(0,0,32'h0,1,0,32'h300,32'h0,32'hA5A5A5A5,1), O(1,0,32'h300,32'h0,0,0,32'h0,32'hA5A5A5A5,0));
    // data abort mid-grant
    add(I(0,0,32'h0,1,0,32'h304,32'h0,32'h0,0),        O(0,0,32'h0,32'h0,0,1,32'h0,32'h0,0));
    add(I(0,0,32'h0,1,0,32'h304,32'h0,32'h0,0),        O(1,0,32'h304,32'h0,0,1,32'h0,32'h0,0));
    add(I(0,0,32'h0,0,0,32'h304,32'h0,32'h0,0),        O(0,0,32'h304,32'h0,0,0,32'h0,32'h0,0));
    add(I(0,0,32'h0,0,0,32'h0,32'h0,32'h0,1),          O(0,0,32'h0,32'h0,0,0,32'h0,32'h0,0));
    // reset in the second data grant cycle
    add(I(0,0,32'h0,0,1,32'h400,32'h77,32'h0,0),       O(0,0,32'h0,32'h0,0,1,32'h0,32'h0,0));
    add(I(0,0,32'h0,0,1,32'h400,32'h77,32'h0,0),       O(0,1,32'h400,32'h77,0,1,32'h0,32'h0,0));
    add(I(1,0,32'h0,0,1,32'h400,32'h77,32'h0,0),       O(0,1,32'h400,32'h77,0,1,32'h0,32'h0,0));
    add(I(0,0,32'h0,0,1,32'h400,32'h77,32'h0,0),       O(0,0,32'h0,32'h0,0,1,32'h0,32'h0,0));
    add(I(0,0,32'h0,0,1,32'h400,32'h77,32'h0,1),       O(0,1,32'h400,32'h77,0,0,32'h0,32'h0,0));
    add(I(0,0,32'h0,0,0,32'h0,32'h0,32'h0,0),          O(0,0,32'h0,32'h0,0,0,32'h0,32'h0,0));
    // instruction abort mid-grant
    add(I(0,1,32'h44,0,0,32'h0,32'h0,32'h0,0),         O(0,0,32'h0,32'h0,1,0,32'h0,32'h0,0));
    add(I(0,0,32'h44,0,0,32'h0,32'h0,32'h0,0),         O(0,0,32'h44,32'h0,0,0,32'h0,32'h0,0));
    add(I(0,0,32'h0,0,0,32'h0,32'h0,32'h0,0),          O(0,0,32'h0,32'h0,0,0,32'h0,32'h0,0));

    foreach (vecs[n]) begin
      drive(vecs[n].i);
      a = sample();
      check($sformatf("vec%0d", n), 200'(a), 200'(vecs[n].o));
    end

    // starvation guard: four data grants, one forced fetch, then data again
    dcomp = 0;
    seen_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      drive(I(0,1,32'h500,1,0,32'h600,32'h0,32'h0,1));
      if (!bus.iwait) seen_i = 1'b1;
      if (!bus.dwait && !seen_i) dcomp++;
      check($sformatf("streak_c%0d", k), 200'({bus.ramREN, bus.ramaddr}),
            200'((k % 2 == 1) ? {1'b1, (k == 9) ? 32'h500 : 32'h600} : 33'h0));
    end
    check("streak_data_before_fetch", 200'(dcomp), 200'(4));

    drive(I(0,0,32'h0,0,0,32'h0,32'h0,32'h0,0));
    drive(I(0,0,32'h0,0,0,32'h0,32'h0,32'h0,0));

    // timeout: err in the 8th grant cycle, wait held, then a re-grant
    for (int k = 0; k < 11; k++) begin
      drive(I(0,1,32'h700,0,0,32'h0,32'h0,32'h0,0));
      check($sformatf("tmo_c%0d", k), 200'({bus.ramREN, bus.ramaddr, bus.err, bus.iwait}),
            200'({((k >= 1 && k <= 8) || k == 10) ? {1'b1, 32'h700} : 33'h0,
                  (k == 8) ? 1'b1 : 1'b0, 1'b1}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
